shift_add_multiplier: RTL

Parametrised sequential shift-and-add multiplier: controller plus datapath in one block, with a `valid_data`/`ack` handshake. It is the successor to the fixed 32-iteration multiplier controller and adds:
- WIDTH-generic operands;
- signed/unsigned mode selected per operation;
- optional early termination when the remaining multiplier bits are zero;
- an iteration-count output.

It sits between an operand source and a result consumer. The result is held until the consumer acknowledges it.

---
 rtl/mult_pkg.sv | 15 +
 rtl/shift_add_datapath.sv | 63 ++++++
 rtl/shift_add_multiplier.sv | 99 +++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-and-add multiplier.
// State encoding plus the iteration-counter width rule.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// Operand registers, accumulator, adder and sign fix-up
// for the sequential shift-and-add multiplier.
module shift_add_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic [2*WIDTH-1:0] product,
  output logic               b_rest_zero
);

  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [PW-1:0]    a_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    sum;
  logic [WIDTH-1:0] b_q;
  logic             neg_q;

  // -2^(W-1) negates to itself, which reads correctly as unsigned
  assign mag_a = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign mag_b = (signed_mode && b[WIDTH-1]) ? -b : b;

  assign addend      = b_q[0] ? a_q : '0;
  assign sum         = acc_q + addend;
  assign b_rest_zero = (b_q[WIDTH-1:1] == '0);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      product <= '0;
    end else begin
      if (load) begin
        a_q   <= {{WIDTH{1'b0}}, mag_a};
        b_q   <= mag_b;
        neg_q <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc_q <= '0;
      end else if (step) begin
        acc_q <= sum;
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
      end
      if (finish) begin
        product <= neg_q ? -sum : sum;
      end
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: FSM controller around
// shift_add_datapath, valid_data/ack handshake, optional early exit.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int EARLY_EXIT = 1
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      valid_data,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  input  logic                      signed_mode,
  output logic                      ready,
  output logic                      done,
  output logic [2*WIDTH-1:0]        product,
  output logic [cnt_w(WIDTH)-1:0]   iterations,
  input  logic                      ack
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic          load;
  logic          step;
  logic          finish;
  logic          b_rest_zero;
  logic          last;

  assign cnt_inc = cnt_q + ONE;
  assign last    = (cnt_inc == LAST) ||
                   ((EARLY_EXIT != 0) && b_rest_zero);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_data) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (last) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ready/done are registered from the next state so they stay Moore
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      iterations <= '0;
      ready      <= 1'b1;
      done       <= 1'b0;
    end else begin
      state_q <= state_d;
      ready   <= (state_d == IDLE);
      done    <= (state_d == DONE);
      if (load) cnt_q <= '0;
      else if (step) cnt_q <= cnt_inc;
      if (finish) iterations <= cnt_inc;
    end
  end

  shift_add_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .Clock       (Clock),
    .Reset       (Reset),
    .load        (load),
    .step        (step),
    .finish      (finish),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .product     (product),
    .b_rest_zero (b_rest_zero)
  );

endmodule
